// File: rtl/payload_byte_feeder.sv
// payload_byte_feeder
//   Serialises a DATA_WIDTH-bit AXI4-Stream payload to one byte per clock for
//   the payload matching engines. Each packet is bracketed by a one-cycle sod
//   pulse (one cycle before the first byte strobe) and a one-cycle eod pulse
//   (one cycle after the last byte strobe) that carries the packet byte count.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   s_tdata    : payload beat, lane 0 = bits [7:0] is the first byte on the wire
//   s_tkeep    : per-lane valid, lanes with keep=0 are skipped
//   s_tvalid   : beat valid
//   s_tlast    : final beat of the packet
//   s_tready   : beat accepted on an edge where s_tvalid && s_tready
//   byte_out   : current payload byte, meaningful while en=1
//   en         : byte strobe (engine clock enable)
//   sod        : start-of-data pulse (engines use it as an asynchronous clear)
//   eod        : end-of-data pulse
//   pkt_len    : bytes emitted for the packet, valid while eod=1, saturating
//   state_dbg  : current FSM state (IDLE=0, SOD=1, STREAM=2, EOD=3)
//
// Handshake: a beat transfers on a rising edge where s_tvalid && s_tready.
// s_tready depends only on registered state (and rst), never on s_tvalid, so
// upstream may hold or drop s_tvalid freely; s_tdata/s_tkeep/s_tlast are only
// sampled on the transfer edge.

module payload_byte_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [7:0]              byte_out,
  output logic                    en,
  output logic                    sod,
  output logic                    eod,
  output logic [LEN_WIDTH-1:0]    pkt_len,
  output logic [1:0]              state_dbg
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SOD    = 2'd1,
    STREAM = 2'd2,
    EOD    = 2'd3
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic [NB-1:0]           buf_keep;
  logic                    buf_last;
  logic                    buf_valid;
  // Set once the final beat is fully emitted (or a keep=0 last beat arrives);
  // the next edge then moves to EOD so eod follows the last byte by one cycle.
  logic                    eod_pend;
  logic [LW-1:0]           lane;
  logic [LEN_WIDTH-1:0]    len_cnt;

  logic [LW-1:0]           first_lane;
  logic [LW-1:0]           next_lane;
  logic                    at_end;
  logic                    emit;
  logic                    consume;
  logic                    accept;

  assign state_dbg = state;

  // first_lane: lowest set keep bit of the incoming beat.
  // next_lane : lowest set keep bit of the buffered beat above the current lane.
  // at_end    : no buffered lane above the current one remains to be emitted.
  always_comb begin
    first_lane = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (s_tkeep[i]) first_lane = LW'(i);
    end
    next_lane = lane;
    at_end    = 1'b1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (buf_keep[i] && (i > int'(lane))) begin
        next_lane = LW'(i);
        at_end    = 1'b0;
      end
    end
  end

  // lane always points at a set keep bit unless the whole beat has keep=0,
  // and keep=0 beats never sit in the buffer, so emit is effectively buf_valid.
  assign emit    = buf_valid && buf_keep[lane];
  assign consume = buf_valid && at_end;

  always_comb begin
    s_tready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    s_tready = 1'b1;
        // Ready either in a bubble or while the last lane of a non-final beat
        // is going out, so the next beat reloads the buffer without a gap.
        STREAM:  s_tready = !eod_pend && (!buf_valid || (at_end && !buf_last));
        default: s_tready = 1'b0;
      endcase
    end
  end

  assign accept = s_tvalid && s_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_keep  <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
      eod_pend  <= 1'b0;
      lane      <= '0;
      len_cnt   <= '0;
      byte_out  <= 8'h00;
      en        <= 1'b0;
      sod       <= 1'b0;
      eod       <= 1'b0;
      pkt_len   <= '0;
    end else begin
      sod <= 1'b0;
      en  <= 1'b0;
      eod <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SOD;
            sod      <= 1'b1;
            len_cnt  <= '0;
            eod_pend <= 1'b0;
          end
        end

        // The first byte is launched on the edge leaving SOD, so en rises
        // exactly one cycle after sod and never overlaps it.
        SOD, STREAM: begin
          if (eod_pend) begin
            state    <= EOD;
            eod      <= 1'b1;
            pkt_len  <= len_cnt;
            eod_pend <= 1'b0;
          end else begin
            state <= STREAM;
            if (emit) begin
              en       <= 1'b1;
              byte_out <= buf_data[8*int'(lane) +: 8];
              lane     <= next_lane;
              if (len_cnt != '1) len_cnt <= len_cnt + LEN_WIDTH'(1);
            end
            if (consume) begin
              buf_valid <= 1'b0;
              if (buf_last) eod_pend <= 1'b1;
            end
          end
        end

        EOD: state <= IDLE;

        default: state <= IDLE;
      endcase

      // Beat load; placed last so it overrides the consume clear above.
      // A keep=0 beat is consumed on arrival and never occupies the buffer.
      if (accept) begin
        buf_data <= s_tdata;
        buf_keep <= s_tkeep;
        buf_last <= s_tlast;
        lane     <= first_lane;
        if (s_tkeep == '0) begin
          buf_valid <= 1'b0;
          if (s_tlast) eod_pend <= 1'b1;
        end else begin
          buf_valid <= 1'b1;
        end
      end
    end
  end

endmodule
